// File: rtl/ps2_rx_fifo_bus.sv
// ps2_rx_fifo_bus: PS/2 keyboard receiver with a scan-code FIFO, read through a
// 68k-style asynchronous bus slave.
//
// Optional feature macro: PS2_PREFIX_FOLD_EN
//   When defined, the 0xE0 and 0xF0 prefix bytes are folded into flag bits
//   that are stored with the next byte. The flags of the last popped entry
//   read back at addr 2.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   ps2_clk, ps2_data   raw PS/2 pins (asynchronous)
//   cs, ds, rw, addr    bus strobes, direction (1 = read) and register select
//   bus_in              write data
//   bus_out, bus_oe     read data and its output enable
//   dtack               data acknowledge, active low
//   irq                 high while the FIFO holds data
//
// Register map:
//   0 R  FIFO head; a read pops it (reads 0x00 when empty)
//   1 R  {ovf, perr, full, empty, count[3:0]}
//   1 W  bit7 clears ovf, bit6 clears perr, bit0 flushes the FIFO
//   2 R  {6'b0, brk, ext} of the last popped entry (0x00 without prefix folding)
//   3 R  0x00
`timescale 1ns/1ps
module ps2_rx_fifo_bus #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       cs,
  input  logic       ds,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       dtack,
  output logic       irq
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PREFIX_FOLD_EN
  localparam int EW  = 10;
`else
  localparam int EW  = 8;
`endif

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_DATA = 2'd1;
  localparam logic [1:0] RX_PAR  = 2'd2;
  localparam logic [1:0] RX_STOP = 2'd3;

  localparam logic [0:0] B_IDLE = 1'b0;
  localparam logic [0:0] B_ACK  = 1'b1;

  // ---------------- input conditioning ----------------
  logic [1:0]     clk_sync, dat_sync;
  logic           clk_filt;
  logic [FCW-1:0] filt_cnt;
  logic           fall;

  // Lines idle high, so the synchronisers and filter reset high to avoid a
  // spurious edge out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // The filtered clock follows the synced clock only after FILTER_LEN
  // consecutive samples disagree with it; fall is a one-cycle pulse on a
  // filtered 1->0 transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
          clk_filt <= clk_sync[1];
          filt_cnt <= '0;
          fall     <= clk_filt;
        end else begin
          filt_cnt <= filt_cnt + FCW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // ---------------- RX frame FSM ----------------
  logic [1:0]    rx_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          frame_done, frame_ok, timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        case (rx_state)
          RX_IDLE: if (!dat_sync[1]) begin
            rx_state <= RX_DATA;
            bit_cnt  <= '0;
          end
          RX_DATA: begin
            shreg   <= {dat_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= RX_PAR;
          end
          RX_PAR: begin
            par_bit  <= dat_sync[1];
            rx_state <= RX_STOP;
          end
          default: begin
            // odd parity over data+parity, and a high stop bit
            frame_done <= 1'b1;
            frame_ok   <= (^{shreg, par_bit}) & dat_sync[1];
            rx_state   <= RX_IDLE;
          end
        endcase
      end else if (rx_state != RX_IDLE) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          rx_state <= RX_IDLE;
          tmo_cnt  <= '0;
          timeout  <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // ---------------- push generation ----------------
  logic          push, perr_set;
  logic [EW-1:0] push_data;

  assign perr_set = frame_done & ~frame_ok;

`ifdef PS2_PREFIX_FOLD_EN
  logic pend_brk, pend_ext, is_e0, is_f0;
  assign is_e0     = (shreg == 8'hE0);
  assign is_f0     = (shreg == 8'hF0);
  assign push      = frame_done & frame_ok & ~is_e0 & ~is_f0;
  assign push_data = {pend_brk, pend_ext, shreg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_brk <= 1'b0;
      pend_ext <= 1'b0;
    end else if (timeout || perr_set) begin
      pend_brk <= 1'b0;
      pend_ext <= 1'b0;
    end else if (frame_done && frame_ok) begin
      if (is_e0)      pend_ext <= 1'b1;
      else if (is_f0) pend_brk <= 1'b1;
      else begin
        pend_brk <= 1'b0;
        pend_ext <= 1'b0;
      end
    end
  end
`else
  assign push      = frame_done & frame_ok;
  assign push_data = shreg;
`endif

  // ---------------- FIFO and status ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [4:0]    cnt_ext;
  logic          full, empty, ovf, perr;
  logic [EW-1:0] head;
  logic [0:0]    bus_state;
  logic          access, rd_acc, wr_acc, pop, flush, clr_ovf, clr_perr, do_push;
  logic [7:0]    status, rd_mux;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign cnt_ext  = 5'(count);
  assign head     = mem[rd_ptr];
  assign status   = {ovf, perr, full, empty, cnt_ext[3:0]};

  // One pop or register write per bus access: only on the B_IDLE cycle.
  assign access   = (bus_state == B_IDLE) & cs & ds;
  assign rd_acc   = access & rw;
  assign wr_acc   = access & ~rw;
  assign pop      = rd_acc & (addr == 2'd0) & ~empty;
  assign flush    = wr_acc & (addr == 2'd1) & bus_in[0];
  assign clr_ovf  = wr_acc & (addr == 2'd1) & bus_in[7];
  assign clr_perr = wr_acc & (addr == 2'd1) & bus_in[6];
  // A same-cycle pop makes room, so a push into a full FIFO still lands.
  assign do_push  = push & (~full | pop) & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(pop);
    end
  end

  // Sticky flags: a same-cycle set beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf  <= 1'b0;
      perr <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (push && full && !pop && !flush) ovf <= 1'b1;
      else if (clr_ovf)                   ovf <= 1'b0;
      if (perr_set)      perr <= 1'b1;
      else if (clr_perr) perr <= 1'b0;
      irq <= ~empty;
    end
  end

`ifdef PS2_PREFIX_FOLD_EN
  logic [1:0] flags_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    flags_q <= 2'b00;
    else if (pop) flags_q <= head[9:8];
  end
`endif

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      2'd0: rd_mux = empty ? 8'h00 : head[7:0];
      2'd1: rd_mux = status;
`ifdef PS2_PREFIX_FOLD_EN
      2'd2: rd_mux = {6'b0, flags_q};
`endif
      default: rd_mux = 8'h00;
    endcase
  end

  // ---------------- bus FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_state <= B_IDLE;
      dtack     <= 1'b1;
      bus_oe    <= 1'b0;
      bus_out   <= 8'h00;
    end else begin
      case (bus_state)
        B_IDLE: if (cs && ds) begin
          bus_state <= B_ACK;
          dtack     <= 1'b0;
          bus_oe    <= rw;
          bus_out   <= rw ? rd_mux : 8'h00;
        end
        default: if (!(cs && ds)) begin
          bus_state <= B_IDLE;
          dtack     <= 1'b1;
          bus_oe    <= 1'b0;
          bus_out   <= 8'h00;
        end
      endcase
    end
  end

  // Write-data bits with no register behind them, and the timeout pulse when
  // prefix folding is off.
  logic unused_bits;
  assign unused_bits = ^{bus_in[5:1], timeout};

endmodule

// File: tb/tb_ps2_rx_fifo_bus.sv
`timescale 1ns/1ps
module tb_ps2_rx_fifo_bus;
  localparam int DEPTH = 8;
  localparam int FLEN  = 4;
  localparam int TMO   = 16384;
  localparam int HP    = 12;               // PS/2 half period in clk cycles
  // clk edges from a ps2_clk fall to the FIFO write: 2 sync flops, FLEN
  // filter samples, the stop-bit edge, then the push on the following clock.
  localparam int PUSH_LAT = 2 + FLEN + 1;

  logic clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1;
  logic cs = 0, ds = 0, rw = 0;
  logic [1:0] addr = 0;
  logic [7:0] bus_in = 0, bus_out;
  logic bus_oe, dtack, irq;

  ps2_rx_fifo_bus #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .cs(cs), .ds(ds), .rw(rw), .addr(addr), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .dtack(dtack), .irq(irq));

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0] mq[$];
  logic [8:0] sb[$];           // {bus_oe, bus_out} expected per bus cycle
  bit m_ovf, m_perr, m_pbrk, m_pext;
  logic [1:0] m_flags;

  task automatic m_reset();
    mq.delete(); sb.delete();
    m_ovf = 0; m_perr = 0; m_pbrk = 0; m_pext = 0; m_flags = 0;
  endtask

  task automatic m_push(input logic [9:0] e);
    if (mq.size() == DEPTH) m_ovf = 1;
    else mq.push_back(e);
  endtask

  task automatic m_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_perr = 1; m_pbrk = 0; m_pext = 0;
    end else begin
`ifdef PS2_PREFIX_FOLD_EN
      if (b == 8'hE0) m_pext = 1;
      else if (b == 8'hF0) m_pbrk = 1;
      else begin
        m_push({m_pbrk, m_pext, b});
        m_pbrk = 0; m_pext = 0;
      end
`else
      m_push({2'b00, b});
`endif
    end
  endtask

  function automatic logic [7:0] m_status();
    int n = mq.size();
    return {m_ovf, m_perr, n == DEPTH, n == 0, 4'(n)};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic dq = 1;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!dtack && dq) begin
        if (sb.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL sb_unexpected: bus cycle with no expected entry, bus_out 0x%0h", bus_out);
        end else begin
          e = sb.pop_front();
          chk("bus_oe", bus_oe, e[8]);
          chk("bus_out", bus_out, e[7:0]);
        end
      end
      dq = dtack;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HP) @(negedge clk);
    ps2_clk = 0;
    repeat (HP) @(negedge clk);
    ps2_clk = 1;
  endtask

  task automatic frame(input logic [7:0] b, input bit badpar = 0, input bit stopb = 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ badpar);
    ps2_bit(stopb);
    ps2_data = 1;
    repeat (HP) @(negedge clk);
    m_frame(b, !badpar && stopb);
  endtask

  task automatic bus_cycle(input logic r, input logic [1:0] a, input logic [7:0] wd);
    int n;
    @(negedge clk);
    cs = 1; ds = 1; rw = r; addr = a; bus_in = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (dtack && n < 16);
    chk("ack_latency", n, 1);
    cs = 0; ds = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!dtack && n < 16);
    chk("release_latency", n, 1);
  endtask

  task automatic bus_read(input logic [1:0] a);
    logic [7:0] v;
    logic [9:0] e;
    v = 8'h00;
    case (a)
      2'd0: if (mq.size() > 0) begin e = mq.pop_front(); v = e[7:0]; m_flags = e[9:8]; end
      2'd1: v = m_status();
`ifdef PS2_PREFIX_FOLD_EN
      2'd2: v = {6'b0, m_flags};
`endif
      default: v = 8'h00;
    endcase
    sb.push_back({1'b1, v});
    bus_cycle(1'b1, a, 8'h00);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    if (a == 2'd1) begin
      if (d[7]) m_ovf = 0;
      if (d[6]) m_perr = 0;
      if (d[0]) mq.delete();
    end
    sb.push_back({1'b0, 8'h00});
    bus_cycle(1'b0, a, d);
  endtask

  // Frame whose stop-bit edge is followed d clk edges later by a bus access
  // (read of addr 0 or write of wd to addr 1). d == PUSH_LAT lands the
  // access on the push cycle.
  task automatic frame_aligned(input logic [7:0] b, input bit is_rd, input logic [7:0] wd, input int d);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b);
    ps2_data = 1;
    repeat (HP) @(negedge clk);
    ps2_clk = 0;
    repeat (d - 1) @(negedge clk);
    if (!is_rd || d > PUSH_LAT) m_frame(b, 1);
    if (is_rd) bus_read(2'd0);
    else bus_write(2'd1, wd);
    if (is_rd && d <= PUSH_LAT) m_frame(b, 1);
    repeat (HP) @(negedge clk);
    ps2_clk = 1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bus_out"}, bus_out, 8'h00);
    chk({tag, "_bus_oe"}, bus_oe, 1'b0);
    chk({tag, "_dtack"}, dtack, 1'b1);
    chk({tag, "_irq"}, irq, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", nchk);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 0;
    repeat (2) @(negedge clk);
    bus_read(2'd1);

    // single byte
    frame(8'h1C);
    n = 0;
    while (!irq && n < 50) begin @(negedge clk); n++; end
    chk("irq_rise", irq, 1'b1);
    bus_read(2'd1);
    bus_read(2'd0);
    chk("irq_fall", irq, 1'b0);
    bus_read(2'd1);

    // parity error
    frame(8'h1C, 1'b1);
    bus_read(2'd1);
    bus_write(2'd1, 8'h40);
    bus_read(2'd1);

    // overflow
    for (int i = 1; i <= 9; i++) frame(8'(i));
    chk("irq_full", irq, 1'b1);
    bus_read(2'd1);
    for (int i = 0; i < 8; i++) bus_read(2'd0);
    bus_write(2'd1, 8'h80);
    bus_read(2'd1);

    // timeout of a partial frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1;
    repeat (TMO + 10) @(negedge clk);
    frame(8'h29);
    bus_read(2'd1);
    bus_read(2'd0);
    bus_read(2'd1);

    // pop before, on, and after the push into a full FIFO
    for (int d = PUSH_LAT - 1; d <= PUSH_LAT + 1; d++) begin
      bus_write(2'd1, 8'hC1);
      for (int i = 0; i < DEPTH; i++) frame(8'h40 + 8'(i));
      frame_aligned(8'h55, 1'b1, 8'h00, d);
      bus_read(2'd1);
      for (int i = 0; i < DEPTH; i++) bus_read(2'd0);
      bus_read(2'd1);
    end
    // flush on the push cycle wins
    bus_write(2'd1, 8'hC1);
    frame_aligned(8'h66, 1'b0, 8'hC1, PUSH_LAT);
    bus_read(2'd1);

    // prefix bytes
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    bus_read(2'd1);
    for (int i = 0; i < 3; i++) bus_read(2'd0);
    bus_read(2'd2);
    bus_read(2'd3);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
                             $urandom_range(0, 9) != 0);
        5, 6: bus_read(2'd0);
        7: bus_read(2'd1);
        8: bus_read(2'($urandom_range(2, 3)));
        default: bus_write(2'($urandom_range(0, 3)),
                           {2'($urandom_range(0, 3)), 5'd0, 1'($urandom_range(0, 3) == 0)});
      endcase
    end
    bus_read(2'd1);

    // reset in the middle of a frame
    ps2_bit(1'b0); ps2_bit(1'b1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_reset_outputs("midreset");
    m_reset();
    reset = 0;
    ps2_data = 1;
    repeat (HP) @(negedge clk);
    bus_read(2'd1);

    repeat (5) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo_bus.md
Name: ps2_rx_fifo_bus

Overview:
- PS/2 keyboard receiver with a parametrised scan-code FIFO and a 68k-style asynchronous bus slave.
- Successor to the single-byte decoder plus bus glue. Adds:
  - ps2_clk glitch filtering
  - odd-parity and stop-bit checking
  - a frame timeout
  - multi-byte buffering with overflow detection
  - a 4-register map with sticky status
  - an interrupt output
- Sits between the PS/2 pins (ui_in) and the 68k data bus (uio_*) at the chip top.

Parameters:
- FIFO_DEPTH, 8: number of scan-code entries; power of 2, range 2..16.
- FILTER_LEN, 4: consecutive identical synced ps2_clk samples required to accept a level change.
- TIMEOUT_CYCLES, 16384: clk cycles without a ps2_clk falling edge before an in-progress frame is aborted.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high; clears all state.
- ps2_clk, input, 1: PS/2 clock pin, asynchronous.
- ps2_data, input, 1: PS/2 data pin, asynchronous.
- cs, input, 1: chip select, active high; synchronous to clk.
- ds, input, 1: data strobe, active high; synchronous to clk.
- rw, input, 1: 1 = read, 0 = write.
- addr, input, 2: register select.
- bus_in, input, 8: write data.
- bus_out, output, 8: read data.
- bus_oe, output, 1: high while bus_out is driven.
- dtack, output, 1: data acknowledge, active low.
- irq, output, 1: high while the FIFO is non-empty.

Behaviour:
- Reset values: bus_out=0x00, bus_oe=0, dtack=1, irq=0. FIFO empty, sticky flags 0, both FSMs idle.
- Input conditioning:
  - ps2_clk and ps2_data each pass through 2-flop synchronisers.
  - Filtered clock changes only after FILTER_LEN equal samples.
  - A falling edge of the filtered clock samples the synced ps2_data.
- RX FSM, one bit per falling edge:
  - IDLE: start bit 0 -> DATA; start bit 1 -> stay IDLE.
  - DATA: 8 bits LSB first -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: always -> IDLE.
- Frame acceptance: good iff data plus parity has an odd count of ones and stop=1.
  - Good frame: push the byte on the clock after the stop edge.
  - Bad frame: set sticky perr; no push.
- Timeout: in any non-IDLE state, TIMEOUT_CYCLES cycles with no falling edge -> IDLE. The partial frame is discarded and no flag is set.
- FIFO: circular buffer; count is clog2(FIFO_DEPTH)+1 bits wide.
  - Push when full and no same-cycle pop: drop the byte and set sticky ovf.
  - Push and pop in the same cycle: both occur, count unchanged. This includes the full case, which is not an overflow.
- irq: registered; equals (count != 0). It rises the cycle after the first push.
- Register map, read side:
  - addr 0: FIFO head. Pops on access. Empty -> 0x00, no pop.
  - addr 1: status = {ovf, perr, full, empty, count[3:0]}.
  - addr 2: flags byte (see optional feature).
  - addr 3: 0x00.
- Register map, write side:
  - addr 1 bit7=1 clears ovf.
  - addr 1 bit6=1 clears perr.
  - addr 1 bit0=1 flushes the FIFO.
  - All other writes are ignored.
- Flush vs push in the same cycle: flush wins and the push is discarded. A flag clear and a same-cycle flag set: set wins.
- Bus FSM, B_IDLE:
  - On the first cycle with cs&ds=1: latch rw and addr, perform the access (at most one pop or write per access), go to B_ACK.
  - On the next cycle, dtack=0. For a read, bus_oe=1 and bus_out holds the value captured at the access edge.
- Bus FSM, B_ACK:
  - Hold outputs until cs=0 or ds=0.
  - Then, next cycle: dtack=1, bus_oe=0, bus_out=0x00, return to B_IDLE.
- Reset asserted mid-frame or mid-bus-cycle: immediate return to reset values; the PS/2 frame is lost.

Optional Feature:
- Macro PS2_PREFIX_FOLD_EN.
- Defined:
  - FIFO entries are 10 bits: {brk, ext, byte}.
  - Good frames 0xE0 set pending ext; good frames 0xF0 set pending brk. Neither is pushed.
  - The next non-prefix byte is pushed with the pending flags, which then clear.
  - A timeout or parity error clears the pending flags.
  - A pop of addr 0 loads the popped entry's flags into a register readable at addr 2 as {6'b0, brk, ext}.
- Undefined:
  - Entries are 8 bits.
  - Prefix bytes are pushed as ordinary data.
  - addr 2 reads 0x00.

Test Plan:
1. Single byte: send frame 0x1C (parity 0, stop 1).
   - irq rises.
   - Read addr1 = 0x01.
   - Read addr0 = 0x1C; dtack low exactly 1 cycle after cs&ds, high 1 cycle after ds falls.
   - irq then falls and addr1 = 0x10.
2. Parity error: send 0x1C with parity 1.
   - No push; addr1 = 0x50.
   - Write 0x40 to addr1; addr1 then reads 0x10.
3. Overflow (FIFO_DEPTH=8): send 9 frames 0x01..0x09.
   - addr1 = 0xA8.
   - 8 reads return 0x01..0x08.
   - Write 0x80 to addr1; addr1 then reads 0x10.
4. Timeout: send start plus 3 data bits, idle TIMEOUT_CYCLES+10, then send frame 0x29.
   - Exactly one entry, 0x29; perr=0.
5. Simultaneous push/pop with FIFO full (8 entries): align a pop with the push.
   - Count stays 8; ovf stays 0; the new byte is read last.
   - Flush write on a push cycle leaves addr1 = 0x10.
6. With PS2_PREFIX_FOLD_EN: send E0, F0, 0x75.
   - Count = 1.
   - Read addr0 = 0x75, then addr2 = 0x03.
   - Without the macro: count = 3 and reads give E0, F0, 75.
